// File: rtl/next_block_queue_pkg.sv
// Shared tetris definitions: colour width, block-type codes and the fetch FSM encoding.
package next_block_queue_pkg;

  localparam int unsigned TETRIS_COLORS_WIDTH = 3;

  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_I = 3'd1;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_J = 3'd2;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_L = 3'd3;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_O = 3'd4;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_S = 3'd5;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_T = 3'd6;
  localparam logic [TETRIS_COLORS_WIDTH-1:0] BLOCK_Z = 3'd7;
  localparam int unsigned BLOCKS_CNT = 7;

  typedef enum logic [1:0] {StIdle, StPulse, StWait, StCapture} fetch_state_e;

  typedef struct packed {
    logic [TETRIS_COLORS_WIDTH-1:0] color;
    logic [1:0]                     rotation;
  } block_t;

  localparam int unsigned BlockW = $bits(block_t);

endpackage

// File: rtl/next_block_queue_if.sv
// Generator and game-logic signals of the next-block queue; slave is the queue itself.
interface next_block_queue_if #(
  parameter int unsigned QUEUE_DEPTH = 2
);
  import next_block_queue_pkg::*;

  localparam int unsigned CountW = $clog2(QUEUE_DEPTH + 1);

  logic                           gen_en_o;
  logic [TETRIS_COLORS_WIDTH-1:0] gen_color_i;
  logic [1:0]                     gen_rotation_i;
  logic                           pop_i;
  logic                           valid_o;
  logic [TETRIS_COLORS_WIDTH-1:0] head_color_o;
  logic [1:0]                     head_rotation_o;
  logic [TETRIS_COLORS_WIDTH-1:0] preview_color_o;
  logic [CountW-1:0]              count_o;
  logic                           err_o;

  modport slave (
    output gen_en_o,
    input  gen_color_i,
    input  gen_rotation_i,
    input  pop_i,
    output valid_o,
    output head_color_o,
    output head_rotation_o,
    output preview_color_o,
    output count_o,
    output err_o
  );

  modport master (
    input  gen_en_o,
    output gen_color_i,
    output gen_rotation_i,
    output pop_i,
    input  valid_o,
    input  head_color_o,
    input  head_rotation_o,
    input  preview_color_o,
    input  count_o,
    input  err_o
  );

endinterface

// File: rtl/block_ring_buf.sv
// Circular buffer with head and head+1 read ports; pops on empty and pushes on full are dropped.
module block_ring_buf #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic [Width-1:0]             next_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   rd_q, wr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CountW'(Depth));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CountW'(do_push) - CountW'(do_pop);
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
  assign next_o  = (count_q >= CountW'(2)) ? mem_q[ptr_inc(rd_q)] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/next_block_queue.sv
// Prefetches upcoming blocks from a fixed-latency generator into a small ring for the game logic.
module next_block_queue
  import next_block_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned GEN_LATENCY = 3
) (
  input logic               clk_i,
  input logic               rst_n_i,
  next_block_queue_if.slave bus
);

  localparam int unsigned CountW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned WaitW  = $clog2(GEN_LATENCY + 1);

  fetch_state_e      state_q;
  logic [WaitW-1:0]  wait_q;
  logic              gen_en_q;
  logic              err_q;
  logic              push;
  logic [CountW-1:0] count;
  block_t            wr_blk, head_blk, next_blk;

  assign wr_blk.color    = bus.gen_color_i;
  assign wr_blk.rotation = bus.gen_rotation_i;
  // Colour 0 is never a real block, so it is dropped rather than queued.
  assign push = (state_q == StCapture) && (bus.gen_color_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      gen_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      gen_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (count < CountW'(QUEUE_DEPTH)) begin
            state_q  <= StPulse;
            gen_en_q <= 1'b1;
          end
        end
        StPulse: begin
          wait_q  <= WaitW'(GEN_LATENCY - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == '0) state_q <= StCapture;
          else              wait_q  <= wait_q - WaitW'(1);
        end
        StCapture: begin
          if (bus.gen_color_i == '0) err_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  block_ring_buf #(
    .Depth (QUEUE_DEPTH),
    .Width (BlockW)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (wr_blk),
    .pop_i   (bus.pop_i),
    .head_o  (head_blk),
    .next_o  (next_blk),
    .count_o (count)
  );

  assign bus.gen_en_o        = gen_en_q;
  assign bus.err_o           = err_q;
  assign bus.count_o         = count;
  assign bus.valid_o         = (count != '0);
  assign bus.head_color_o    = head_blk.color;
  assign bus.head_rotation_o = head_blk.rotation;
  assign bus.preview_color_o = next_blk.color;

endmodule

// File: tb/tb_next_block_queue.sv
// Directed scenarios followed by randomized pops/resets/colours, checked every cycle against a queue model.
module tb_next_block_queue;
  import next_block_queue_pkg::*;

  localparam int unsigned Depth = 2;
  localparam int unsigned Lat   = 3;

  typedef struct {
    int color;
    int rot;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  next_block_queue_if #(.QUEUE_DEPTH(Depth)) bus ();

  next_block_queue #(
    .QUEUE_DEPTH (Depth),
    .GEN_LATENCY (Lat)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the queue contents plus the cycle numbers of the next fetch decision/pulse.
  ent_t q[$];
  ent_t gen_script[$];
  int   err_m      = 0;
  int   cyc        = 0;
  int   pulse_cyc  = -100;
  int   decide_cyc = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic compare_outputs();
    int   sz;
    ent_t h;
    int   pv;
    sz = q.size();
    h  = '{color: 0, rot: 0};
    pv = 0;
    if (sz > 0) h = q[0];
    if (sz > 1) pv = q[1].color;
    check_eq("gen_en",   32'(bus.gen_en_o),        32'(cyc == pulse_cyc));
    check_eq("valid",    32'(bus.valid_o),         32'(sz != 0));
    check_eq("count",    32'(bus.count_o),         32'(sz));
    check_eq("err",      32'(bus.err_o),           32'(err_m));
    check_eq("head_col", 32'(bus.head_color_o),    32'(h.color));
    check_eq("head_rot", 32'(bus.head_rotation_o), 32'(h.rot));
    check_eq("preview",  32'(bus.preview_color_o), 32'(pv));
  endtask

  task automatic model_update(input logic r, input logic p);
    int   pre;
    bit   do_push;
    ent_t e;
    pre     = q.size();
    do_push = 0;
    if (!r) begin
      q.delete();
      err_m      = 0;
      pulse_cyc  = -100;
      decide_cyc = cyc + 1;
      return;
    end
    if (cyc == decide_cyc) begin
      if (pre < int'(Depth)) pulse_cyc = cyc + 1;
      else                   decide_cyc = cyc + 1;
    end
    if (pulse_cyc >= 0 && cyc == pulse_cyc + int'(Lat) + 1) begin
      decide_cyc = cyc + 1;
      if (bus.gen_color_i != '0) do_push = 1;
      else                       err_m   = 1;
    end
    if (p && pre > 0) void'(q.pop_front());
    if (do_push) begin
      e.color = int'(bus.gen_color_i);
      e.rot   = int'(bus.gen_rotation_i);
      q.push_back(e);
    end
  endtask

  task automatic next_gen_value();
    ent_t e;
    if (gen_script.size() > 0) begin
      e = gen_script.pop_front();
    end else begin
      e.color = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, BLOCKS_CNT));
      e.rot   = int'($urandom_range(0, 3));
    end
    bus.gen_color_i    = 3'(e.color);
    bus.gen_rotation_i = 2'(e.rot);
  endtask

  task automatic run_cycle(input logic r, input logic p);
    @(negedge clk);
    if (cyc > 0) compare_outputs();
    if (bus.gen_en_o === 1'b1) next_gen_value();
    rst_n     = r;
    bus.pop_i = p;
    @(posedge clk);
    model_update(r, p);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    gen_script.delete();
    repeat (n) run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    bus.pop_i          = 1'b0;
    bus.gen_color_i    = 3'd3;
    bus.gen_rotation_i = 2'd1;

    // Constant colour 3 / rotation 1: fill to full, fetching stops.
    do_reset(2);
    repeat (3) gen_script.push_back('{color: 3, rot: 1});
    repeat (20) run_cycle(1'b1, 1'b0);

    // Fill with 5 then 2, single pop, then a pop landing on the refill capture edge.
    do_reset(2);
    gen_script.push_back('{color: 5, rot: 0});
    gen_script.push_back('{color: 2, rot: 3});
    repeat (16) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    repeat (5) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    repeat (12) run_cycle(1'b1, 1'b0);

    // Illegal colour once, then a legal refetch.
    do_reset(2);
    gen_script.push_back('{color: 0, rot: 0});
    gen_script.push_back('{color: 4, rot: 2});
    repeat (24) run_cycle(1'b1, 1'b0);

    // Reset while waiting on the generator.
    do_reset(2);
    repeat (3) run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    repeat (15) run_cycle(1'b1, 1'b0);

    // Pop held on an empty queue, then normal fill.
    do_reset(2);
    repeat (10) run_cycle(1'b1, 1'b1);
    repeat (15) run_cycle(1'b1, 1'b0);

    // Random pops, occasional resets and illegal colours.
    for (int i = 0; i < 1500; i++) begin
      run_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0));
    end
    run_cycle(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
